crop_scaler: RTL and testbench
==============================

CROP_SCALER -- requirements
Module: crop_scaler

Interface
REQ-001 Parameter IMG_W, default 200, source image width in pixels.
REQ-002 Parameter IMG_H, default 150, source image height in pixels.
REQ-003 Parameter PIX_W, default 8, pixel width in bits.
REQ-004 Parameter ADDR_W, default 15, memory address width; SHALL satisfy 2^ADDR_W >= IMG_W*IMG_H.
REQ-005 Parameter COORD_W, default 11, coordinate width.
REQ-006 Parameter RD_LAT, default 1, source read latency in cycles (1..4).
REQ-007 clk  in  1  sole clock; all logic on rising edge.
REQ-008 rst_n  in  1  asynchronous, active-low reset.
REQ-009 start  in  1  request; sampled only in IDLE or DONE.
REQ-010 x_min, x_max, y_min, y_max  in  COORD_W each  inclusive crop box.
REQ-011 scale  in  2  decimation exponent; step = 2^scale (1, 2, 4, 8).
REQ-012 rd_en / rd_addr  out  1 / ADDR_W  source read request and address.
REQ-013 rd_data  in  PIX_W  source pixel, valid RD_LAT cycles after rd_en.
REQ-014 wr_en / wr_addr / wr_data  out  1 / ADDR_W / PIX_W  destination write.
REQ-015 busy, done, err  out  1 each  status; done is a 1-cycle pulse.
REQ-016 out_w, out_h  out  COORD_W each  output image dimensions.

Function
REQ-017 States: IDLE, CHECK, RUN, DRAIN, DONE.
REQ-018 IDLE/DONE + start=1: latch box and scale, go CHECK, busy=1, err=0; start ignored in CHECK/RUN/DRAIN.
REQ-019 CHECK (1 cycle): xc = min(x_max, IMG_W-1), yc = min(y_max, IMG_H-1).
REQ-020 CHECK invalid (x_min>xc or y_min>yc): err=1, next state DONE, zero reads/writes.
REQ-021 CHECK valid: out_w = ((xc-x_min)>>scale)+1, out_h = ((yc-y_min)>>scale)+1; x=x_min, y=y_min; go RUN.
REQ-022 RUN: rd_en=1 every cycle, rd_addr = y*IMG_W + x, truncated to ADDR_W.
REQ-023 Scan: x += step; if x+step > xc then x = x_min, y += step; the read at (last x, last y) is final; go DRAIN.
REQ-024 Each rd_en SHALL produce exactly one wr_en RD_LAT cycles later with wr_data = rd_data at that cycle.
REQ-025 wr_addr starts at 0 per job and increments by 1 per write; total writes = out_w*out_h.
REQ-026 DRAIN: hold RD_LAT cycles until last write issued, then DONE.
REQ-027 DONE (1 cycle): done=1, busy=0; next state IDLE unless start=1 (then CHECK).
REQ-028 out_w, out_h, err SHALL hold until the next accepted start.
REQ-029 Valid-job latency: start sampled -> done = N + RD_LAT + 2 cycles, N = out_w*out_h.
REQ-030 Coordinate arithmetic SHALL be COORD_W+1 bits wide so x+step never wraps.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE; busy, done, err, rd_en, wr_en = 0; rd_addr, wr_addr, wr_data, out_w, out_h = 0.
REQ-032 Reads in flight at reset SHALL be discarded; no wr_en after rst_n rises until a new start.
REQ-033 First start after reset release SHALL run a complete, correct job.

Verification
REQ-034 Box (10,20,60,70), scale=0 -> 121 writes, first rd_addr=12010, last rd_addr=14020, wr_addr 0..120, out_w=out_h=11, one done pulse.
REQ-035 Same box, scale=1 -> x 10,12..20, y 60,62..70, 36 writes, out_w=out_h=6, last rd_addr=14020.
REQ-036 Box (190,250,0,0), scale=0 -> x clamped to 199, 10 writes, rd_addr 190..199, out_w=10, out_h=1.
REQ-037 Box (30,20,5,5) -> err=1, done pulse 2 cycles after start, zero rd_en/wr_en.
REQ-038 rst_n low mid-RUN after 50 writes -> all outputs 0 asynchronously, no further wr_en; next start completes 121 writes.
REQ-039 RD_LAT=3, start pulsed again while busy -> ignored; every wr_en trails its rd_en by 3 cycles, data matches memory model.

Source files
------------

// File: rtl/crop_scaler.sv
// crop_scaler: crops a box from a source image, decimates it by 2^scale and streams it to a destination memory
//   clk, rst_n              : clock, asynchronous active-low reset
//   start, x/y_min/max, scale : job request, inclusive crop box, decimation exponent
//   rd_en/rd_addr/rd_data   : source read port, data returns RD_LAT cycles after rd_en
//   wr_en/wr_addr/wr_data   : destination write port, packed output image from address 0
//   busy, done, err         : status; done is a one-cycle pulse
//   out_w, out_h            : output image dimensions of the last accepted job
module crop_scaler #(
  parameter int IMG_W   = 200,
  parameter int IMG_H   = 150,
  parameter int PIX_W   = 8,
  parameter int ADDR_W  = 15,
  parameter int COORD_W = 11,
  parameter int RD_LAT  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [COORD_W-1:0] x_min,
  input  logic [COORD_W-1:0] x_max,
  input  logic [COORD_W-1:0] y_min,
  input  logic [COORD_W-1:0] y_max,
  input  logic [1:0]         scale,
  output logic               rd_en,
  output logic [ADDR_W-1:0]  rd_addr,
  input  logic [PIX_W-1:0]   rd_data,
  output logic               wr_en,
  output logic [ADDR_W-1:0]  wr_addr,
  output logic [PIX_W-1:0]   wr_data,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [COORD_W-1:0] out_w,
  output logic [COORD_W-1:0] out_h
);
  typedef logic [COORD_W:0] c_t;
  typedef enum logic [2:0] {IDLE, CHECK, RUN, DRAIN, DONE} st_t;
  localparam logic [ADDR_W-1:0] ROW = ADDR_W'(IMG_W);
  st_t st_q, st_d;
  c_t x_q, y_q, x0_q, y0_q, x1_q, y1_q;
  c_t xc, yc, step, xn, yn;
  logic [1:0] sc_q;
  logic [2:0] cnt_q;
  logic [RD_LAT-1:0] vld_q;
  logic [ADDR_W-1:0] wa_q, addr;
  logic [COORD_W-1:0] ow_q, oh_q;
  logic err_q, bad, x_wrap, last, accept;
  always_comb begin
    xc = x1_q > c_t'(IMG_W-1) ? c_t'(IMG_W-1) : x1_q;
    yc = y1_q > c_t'(IMG_H-1) ? c_t'(IMG_H-1) : y1_q;
    bad = x0_q > xc || y0_q > yc;
    step = c_t'(1) << sc_q;
    xn = x_q + step;
    yn = y_q + step;
    // x1_q/y1_q hold the clamped limits once CHECK has run
    x_wrap = xn > x1_q;
    last = x_wrap && yn > y1_q;
    accept = start && (st_q == IDLE || st_q == DONE);
    addr = ADDR_W'(y_q) * ROW + ADDR_W'(x_q);
    st_d = accept ? CHECK :
           st_q == CHECK ? (bad ? DONE : RUN) :
           st_q == RUN ? (last ? DRAIN : RUN) :
           st_q == DRAIN ? (cnt_q == 3'(RD_LAT-1) ? DONE : DRAIN) : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q <= IDLE;
      {x_q, y_q, x0_q, y0_q, x1_q, y1_q} <= '0;
      sc_q <= '0;
      cnt_q <= '0;
      vld_q <= '0;
      wa_q <= '0;
      ow_q <= '0;
      oh_q <= '0;
      err_q <= 1'b0;
    end else begin
      st_q <= st_d;
      // one valid bit per outstanding read; the oldest becomes the write strobe
      vld_q <= (vld_q << 1) | RD_LAT'(rd_en);
      cnt_q <= st_q == DRAIN ? cnt_q + 3'd1 : 3'd0;
      if (wr_en) wa_q <= wa_q + 1'b1;
      if (accept) begin
        x0_q <= c_t'(x_min);
        x1_q <= c_t'(x_max);
        y0_q <= c_t'(y_min);
        y1_q <= c_t'(y_max);
        sc_q <= scale;
        err_q <= 1'b0;
        ow_q <= '0;
        oh_q <= '0;
        wa_q <= '0;
      end
      if (st_q == CHECK) begin
        x1_q <= xc;
        y1_q <= yc;
        x_q <= x0_q;
        y_q <= y0_q;
        err_q <= bad;
        ow_q <= bad ? '0 : COORD_W'((xc - x0_q) >> sc_q) + 1'b1;
        oh_q <= bad ? '0 : COORD_W'((yc - y0_q) >> sc_q) + 1'b1;
      end
      if (st_q == RUN) begin
        x_q <= x_wrap ? x0_q : xn;
        y_q <= x_wrap ? yn : y_q;
      end
    end
  end
  assign rd_en = st_q == RUN;
  assign rd_addr = rd_en ? addr : '0;
  assign wr_en = vld_q[RD_LAT-1];
  assign wr_addr = wa_q;
  assign wr_data = wr_en ? rd_data : '0;
  assign busy = st_q inside {CHECK, RUN, DRAIN};
  assign done = st_q == DONE;
  assign err = err_q;
  assign out_w = ow_q;
  assign out_h = oh_q;
endmodule

// File: tb/tb_crop_scaler.sv
// tb_crop_scaler: scoreboard bench running RD_LAT=1 and RD_LAT=3 scalers side by side on the same jobs
module tb_crop_scaler;
  logic clk = 0, rst_n = 1, start = 0;
  logic [10:0] x_min = 0, x_max = 0, y_min = 0, y_max = 0;
  logic [1:0] scale = 0;
  logic rd_en_w[2], wr_en_w[2], busy_w[2], done_w[2], err_w[2];
  logic [14:0] rd_addr_w[2], wr_addr_w[2];
  logic [7:0] rd_data_w[2], wr_data_w[2];
  logic [10:0] out_w_w[2], out_h_w[2];
  int checks = 0, failures = 0, cyc = 0;
  int erd[2][$], ewa[2][$], ewd[2][$], rcyc[2][$];
  int nwr[2], nrd[2], ndone[2], dcyc[2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic logic [7:0] pix(input int a);
    return 8'((a * 37) ^ (a >> 5));
  endfunction

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int L = (g == 1) ? 3 : 1;
    logic [14:0] pa [4];
    crop_scaler #(.RD_LAT(L)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max), .scale(scale),
      .rd_en(rd_en_w[g]), .rd_addr(rd_addr_w[g]), .rd_data(rd_data_w[g]),
      .wr_en(wr_en_w[g]), .wr_addr(wr_addr_w[g]), .wr_data(wr_data_w[g]),
      .busy(busy_w[g]), .done(done_w[g]), .err(err_w[g]),
      .out_w(out_w_w[g]), .out_h(out_h_w[g])
    );
    assign rd_data_w[g] = pix(int'(pa[L-1]));
    always @(posedge clk) begin
      pa[0] <= rd_addr_w[g];
      for (int i = 1; i < 4; i++) pa[i] <= pa[i-1];
    end
    always @(negedge clk) begin
      int e, d, r;
      if (rd_en_w[g]) begin
        nrd[g]++;
        rcyc[g].push_back(cyc);
        e = erd[g].size() ? erd[g].pop_front() : -1;
        checks++;
        if (e < 0 || rd_addr_w[g] !== 15'(e)) begin
          failures++;
          $display("FAIL rd_addr lane%0d got=%0d exp=%0d", g, rd_addr_w[g], e);
        end
      end
      if (wr_en_w[g]) begin
        nwr[g]++;
        e = ewa[g].size() ? ewa[g].pop_front() : -1;
        d = ewd[g].size() ? ewd[g].pop_front() : -1;
        r = rcyc[g].size() ? rcyc[g].pop_front() : -1000;
        checks += 3;
        if (e < 0 || wr_addr_w[g] !== 15'(e)) begin
          failures++;
          $display("FAIL wr_addr lane%0d got=%0d exp=%0d", g, wr_addr_w[g], e);
        end
        if (d < 0 || wr_data_w[g] !== 8'(d)) begin
          failures++;
          $display("FAIL wr_data lane%0d got=%0d exp=%0d", g, wr_data_w[g], d);
        end
        if (cyc - r != L) begin
          failures++;
          $display("FAIL wr_latency lane%0d got=%0d exp=%0d", g, cyc - r, L);
        end
      end
      if (done_w[g]) begin
        ndone[g]++;
        dcyc[g] = cyc;
      end
    end
  end

  task automatic flush();
    for (int g = 0; g < 2; g++) begin
      erd[g].delete();
      ewa[g].delete();
      ewd[g].delete();
      rcyc[g].delete();
    end
  endtask

  task automatic push_job(input int x0, x1, y0, y1, sc, output int n, w, h);
    int xc = x1 > 199 ? 199 : x1;
    int yc = y1 > 149 ? 149 : y1;
    int s = 1 << sc;
    n = 0;
    w = 0;
    h = 0;
    if (x0 > xc || y0 > yc) return;
    for (int y = y0; y <= yc; y += s)
      for (int x = x0; x <= xc; x += s) begin
        for (int g = 0; g < 2; g++) begin
          erd[g].push_back(y * 200 + x);
          ewa[g].push_back(n);
          ewd[g].push_back(int'(pix(y * 200 + x)));
        end
        n++;
      end
    w = (xc - x0) / s + 1;
    h = (yc - y0) / s + 1;
  endtask

  task automatic run_job(input string nm, input int x0, x1, y0, y1, sc, input bit poke);
    int n, w, h, s0, lat;
    int w0[2], r0[2], d0[2];
    bit ok = 0;
    push_job(x0, x1, y0, y1, sc, n, w, h);
    for (int g = 0; g < 2; g++) begin
      w0[g] = nwr[g];
      r0[g] = nrd[g];
      d0[g] = ndone[g];
    end
    @(negedge clk);
    x_min = 11'(x0); x_max = 11'(x1); y_min = 11'(y0); y_max = 11'(y1); scale = 2'(sc);
    start = 1;
    s0 = cyc;
    @(negedge clk);
    start = 0;
    if (poke) begin
      repeat (4) @(negedge clk);
      start = 1;
      x_min = 0;
      scale = 0;
      @(negedge clk);
      start = 0;
    end
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(posedge clk);
      ok = ndone[0] > d0[0] && ndone[1] > d0[1];
    end
    repeat (4) @(posedge clk);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s timeout done0=%0d done1=%0d", nm, ndone[0] - d0[0], ndone[1] - d0[1]);
    end
    for (int g = 0; g < 2; g++) begin
      lat = g ? 3 : 1;
      checks += 7;
      if (nwr[g] - w0[g] != n) begin failures++; $display("FAIL %s writes lane%0d got=%0d exp=%0d", nm, g, nwr[g] - w0[g], n); end
      if (nrd[g] - r0[g] != n) begin failures++; $display("FAIL %s reads lane%0d got=%0d exp=%0d", nm, g, nrd[g] - r0[g], n); end
      if (ndone[g] - d0[g] != 1) begin failures++; $display("FAIL %s done_pulses lane%0d got=%0d exp=1", nm, g, ndone[g] - d0[g]); end
      if (dcyc[g] - s0 != (n ? n + lat + 2 : 2)) begin failures++; $display("FAIL %s latency lane%0d got=%0d exp=%0d", nm, g, dcyc[g] - s0, n ? n + lat + 2 : 2); end
      if (err_w[g] !== (n == 0)) begin failures++; $display("FAIL %s err lane%0d got=%0b exp=%0b", nm, g, err_w[g], n == 0); end
      if (busy_w[g] !== 1'b0) begin failures++; $display("FAIL %s busy lane%0d got=%0b exp=0", nm, g, busy_w[g]); end
      if (erd[g].size() + ewa[g].size() != 0) begin failures++; $display("FAIL %s leftover lane%0d got=%0d exp=0", nm, g, erd[g].size() + ewa[g].size()); end
      if (n != 0) begin
        checks++;
        if (out_w_w[g] !== 11'(w) || out_h_w[g] !== 11'(h)) begin
          failures++;
          $display("FAIL %s dims lane%0d got=%0dx%0d exp=%0dx%0d", nm, g, out_w_w[g], out_h_w[g], w, h);
        end
      end
    end
    flush();
  endtask

  task automatic test_reset();
    #1 rst_n = 0;
    #2;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({busy_w[g], done_w[g], err_w[g], rd_en_w[g], wr_en_w[g], rd_addr_w[g], wr_addr_w[g],
           wr_data_w[g], out_w_w[g], out_h_w[g]} !== '0) begin
        failures++;
        $display("FAIL reset_outputs lane%0d got busy=%0b done=%0b err=%0b rd_en=%0b wr_en=%0b exp all zero",
                 g, busy_w[g], done_w[g], err_w[g], rd_en_w[g], wr_en_w[g]);
      end
    end
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full();      run_job("full", 10, 20, 60, 70, 0, 0);   endtask
  task automatic test_decimate();  run_job("decimate", 10, 20, 60, 70, 1, 0); endtask
  task automatic test_clamp();     run_job("clamp", 190, 250, 0, 0, 0, 0);  endtask
  task automatic test_scale3();    run_job("scale3", 0, 2047, 0, 2047, 3, 0); endtask
  task automatic test_single();    run_job("single", 5, 5, 5, 5, 2, 0);     endtask

  task automatic test_err();
    run_job("err_x", 30, 20, 5, 5, 0, 0);
    repeat (5) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (err_w[g] !== 1'b1) begin failures++; $display("FAIL err_hold lane%0d got=%0b exp=1", g, err_w[g]); end
    end
    run_job("err_y", 0, 10, 160, 170, 0, 0);
  endtask

  task automatic test_back_to_back();
    run_job("busy_start", 10, 20, 60, 70, 0, 1);
    run_job("next_job", 3, 40, 7, 21, 2, 0);
  endtask

  task automatic test_async_reset();
    int n, w, h, w0[2];
    bit ok = 0;
    push_job(10, 20, 60, 70, 0, n, w, h);
    w0[0] = nwr[0];
    @(negedge clk);
    x_min = 10; x_max = 20; y_min = 60; y_max = 70; scale = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 500 && !ok; i++) begin
      @(posedge clk);
      ok = nwr[0] - w0[0] >= 50;
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL async_reset wait got=%0d exp=50 writes", nwr[0] - w0[0]); end
    #2 rst_n = 0;
    #1;
    for (int g = 0; g < 2; g++) begin
      checks++;
      if ({busy_w[g], done_w[g], err_w[g], rd_en_w[g], wr_en_w[g], rd_addr_w[g], wr_addr_w[g],
           wr_data_w[g], out_w_w[g], out_h_w[g]} !== '0) begin
        failures++;
        $display("FAIL async_reset_outputs lane%0d got rd_en=%0b wr_en=%0b busy=%0b out_w=%0d exp all zero",
                 g, rd_en_w[g], wr_en_w[g], busy_w[g], out_w_w[g]);
      end
    end
    flush();
    repeat (3) @(negedge clk);
    rst_n = 1;
    w0[0] = nwr[0];
    w0[1] = nwr[1];
    repeat (10) @(posedge clk);
    for (int g = 0; g < 2; g++) begin
      checks++;
      if (nwr[g] != w0[g]) begin failures++; $display("FAIL post_reset_writes lane%0d got=%0d exp=0", g, nwr[g] - w0[g]); end
    end
    run_job("after_reset", 10, 20, 60, 70, 0, 0);
  endtask

  initial begin
    test_reset();
    test_full();
    test_decimate();
    test_clamp();
    test_scale3();
    test_single();
    test_err();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
